// File: rtl/mac_dot_ctrl.sv
// Sequencer for a signed multiply-accumulate dot product of len operand pairs.
// Optional saturating accumulate with sticky overflow flag: define MAC_DOT_CTRL_SAT_EN.
module mac_dot_ctrl #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int LEN_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [LEN_W-1:0]         len,
   output logic                     busy,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_a,
   input  logic signed [DATA_W-1:0] in_b,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic signed [ACC_W-1:0]  out_z,
   input  logic                     out_ready,
   output logic                     ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e                    state_q, state_d;
   logic [LEN_W-1:0]          cnt_q, cnt_d;
   logic signed [DATA_W-1:0]  a_q, a_d;
   logic signed [DATA_W-1:0]  b_q, b_d;
   logic                      pend_q, pend_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic signed [ACC_W-1:0]   out_z_q, out_z_d;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]   acc_next;
   logic                      accept;

`ifdef MAC_DOT_CTRL_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   logic                      ovf_q, ovf_d;
   logic signed [ACC_W:0]     sum_wide;
   logic                      clamp;
`endif

   always_comb begin
      // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      pend_d   = 1'b0;
      acc_d    = acc_q;
      out_z_d  = out_z_q;
      accept   = 1'b0;

      prod = (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);
`ifdef MAC_DOT_CTRL_SAT_EN
      ovf_d    = ovf_q;
      sum_wide = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod);
      clamp    = sum_wide[ACC_W] != sum_wide[ACC_W-1];
      if (!clamp)
         acc_next = sum_wide[ACC_W-1:0];
      else if (sum_wide[ACC_W])
         acc_next = ACC_MIN;
      else
         acc_next = ACC_MAX;
      if (pend_q && clamp)
         ovf_d = 1'b1;
`else
      acc_next = acc_q + ACC_W'(prod);
`endif

      if (pend_q)
         acc_d = acc_next;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d = '0;
               cnt_d = len;
`ifdef MAC_DOT_CTRL_SAT_EN
               ovf_d = 1'b0;
`endif
               if (len == '0) begin
                  out_z_d = '0;
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            accept = in_valid;
            if (accept) begin
               a_d    = in_a;
               b_d    = in_b;
               pend_d = 1'b1;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1))
                  state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The last product lands in acc on this edge; publish the folded value.
            out_z_d = acc_d;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         pend_q  <= 1'b0;
         acc_q   <= '0;
         out_z_q <= '0;
`ifdef MAC_DOT_CTRL_SAT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pend_q  <= pend_d;
         acc_q   <= acc_d;
         out_z_q <= out_z_d;
`ifdef MAC_DOT_CTRL_SAT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy      = state_q != S_IDLE;
   assign in_ready  = state_q == S_RUN;
   assign out_valid = state_q == S_DONE;
   assign out_z     = out_z_q;
`ifdef MAC_DOT_CTRL_SAT_EN
   assign ovf       = ovf_q;
`else
   assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Scoreboard bench for mac_dot_ctrl: directed runs push expected results, a monitor pops on handshake.
// Expected values follow MAC_DOT_CTRL_SAT_EN when it is defined for the build.
module tb_mac_dot_ctrl;

`ifdef MAC_DOT_CTRL_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [7:0]        len;
   logic              busy;
   logic              in_valid;
   logic signed [7:0] in_a;
   logic signed [7:0] in_b;
   logic              in_ready;
   logic              out_valid;
   logic [15:0]       out_z;
   logic              out_ready;
   logic              ovf;

   typedef struct packed {
      logic [15:0] z;
      logic        ovf;
   } exp_t;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   beats_acc   = 0;
   int   busy_cycles = 0;

   mac_dot_ctrl #(.DATA_W(8), .ACC_W(16), .LEN_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_z     (out_z),
      .out_ready (out_ready),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   task automatic push_exp(input logic [15:0] z, input logic o);
      exp_t e;
      e.z   = z;
      e.ovf = o;
      sb_q.push_back(e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (!busy) return;
      end
      timeout("wait_idle");
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (out_valid) return;
      end
      timeout("wait_valid");
   endtask

   task automatic do_start(input logic [7:0] l);
      wait_idle();
      start = 1'b1;
      len   = l;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Presents one pair and returns 1 time unit after the edge that accepted it.
   task automatic send_beat(input logic signed [7:0] a, input logic signed [7:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            return;
         end
         @(posedge clk);
         #1;
      end
      timeout("send_beat");
   endtask

   // Monitor: scoreboard pop on every result handshake, plus beat and busy counters.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && in_valid && in_ready) beats_acc++;
      if (busy) busy_cycles++;
      if (reset_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            timeout("unexpected_result");
         end else begin
            e = sb_q.pop_front();
            check("out_z", 32'(out_z), 32'(e.z));
            check("ovf", 32'(ovf), 32'(e.ovf));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held_z;
      reset_n   = 1'b0;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 32'({busy, in_ready, out_valid, ovf, out_z}), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Basic dot product, in_valid held high: 5+12+21+32 = 70.
      busy_cycles = 0;
      push_exp(16'h0046, 1'b0);
      do_start(8'd4);
      send_beat(8'sd1, 8'sd5);
      send_beat(8'sd2, 8'sd6);
      send_beat(8'sd3, 8'sd7);
      send_beat(8'sd4, 8'sd8);
      in_valid = 1'b0;
      wait_valid();
      wait_idle();
      check("busy_cycles_len4", 32'(busy_cycles), 32'd6);

      // 16384 + 16384 = 32768: wraps to 0x8000, or clamps to 0x7FFF.
      push_exp(SAT ? 16'h7FFF : 16'h8000, SAT);
      do_start(8'd2);
      send_beat(-8'sd128, -8'sd128);
      send_beat(-8'sd128, -8'sd128);
      in_valid = 1'b0;
      wait_valid();

      // 4 x 16384 = 65536: wraps to 0x0000.
      push_exp(SAT ? 16'h7FFF : 16'h0000, SAT);
      do_start(8'd4);
      for (int i = 0; i < 4; i++) send_beat(-8'sd128, -8'sd128);
      in_valid = 1'b0;
      wait_valid();

      // 3 x -16256 = -48768: wraps to 0x4180, or clamps to 0x8000.
      push_exp(SAT ? 16'h8000 : 16'h4180, SAT);
      do_start(8'd3);
      for (int i = 0; i < 3; i++) send_beat(-8'sd128, 8'sd127);
      in_valid = 1'b0;
      wait_valid();

      // Maximum length: 255 x 16129 = 4112895 = 0x3EC1FF, low half 0xC1FF.
      push_exp(SAT ? 16'h7FFF : 16'hC1FF, SAT);
      do_start(8'd255);
      for (int i = 0; i < 255; i++) send_beat(8'sd127, 8'sd127);
      in_valid = 1'b0;
      wait_valid();

      // len=0 completes straight away; start during the DONE handshake is dropped.
      push_exp(16'h0000, 1'b0);
      wait_idle();
      @(posedge clk);
      #1 start = 1'b1;
      len = 8'd0;
      @(posedge clk);
      #1 len = 8'd5;
      @(negedge clk);
      check("len0_out_valid", 32'(out_valid), 32'd1);
      check("len0_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("start_at_handshake_ignored", 32'(busy), 32'd0);

      // Gappy input and a stalled consumer: -7+14-21 = -14; ovf clears on the new start.
      out_ready = 1'b0;
      beats_acc = 0;
      push_exp(16'hFFF2, 1'b0);
      do_start(8'd3);
      send_beat(-8'sd1, 8'sd7);
      in_valid = 1'b0;
      @(posedge clk);
      #1 send_beat(8'sd2, 8'sd7);
      in_valid = 1'b0;
      @(posedge clk);
      #1 send_beat(-8'sd3, 8'sd7);
      in_valid = 1'b0;
      wait_valid();
      held_z = out_z;
      repeat (5) @(negedge clk);
      check("stall_out_z_held", 32'(out_z), 32'(held_z));
      check("stall_out_valid_held", 32'(out_valid), 32'd1);
      check("stall_beats_accepted", 32'(beats_acc), 32'd3);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_idle();

      // start with len=9 mid-run is ignored: 2+3+4+5 = 14.
      push_exp(16'h000E, 1'b0);
      do_start(8'd4);
      send_beat(8'sd2, 8'sd1);
      start = 1'b1;
      len   = 8'd9;
      send_beat(8'sd3, 8'sd1);
      start = 1'b0;
      send_beat(8'sd4, 8'sd1);
      send_beat(8'sd5, 8'sd1);
      in_valid = 1'b0;
      wait_valid();
      wait_idle();

      // Reset in the middle of a run aborts it with no result.
      do_start(8'd4);
      send_beat(8'sd7, 8'sd7);
      send_beat(8'sd7, 8'sd7);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrun_reset_outputs", 32'({busy, in_ready, out_valid, ovf, out_z}), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      push_exp(16'h0046, 1'b0);
      do_start(8'd4);
      send_beat(8'sd1, 8'sd5);
      send_beat(8'sd2, 8'sd6);
      send_beat(8'sd3, 8'sd7);
      send_beat(8'sd4, 8'sd8);
      in_valid = 1'b0;
      wait_valid();
      wait_idle();

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
